// File: rtl/i2s_serializer.sv
// Stereo 24-bit to I2S serializer (sck/ws/sdo) with a one-sample prefetch buffer and per-frame request.
// Build option I2S_HOLD_LAST_EN: an underrun repeats the last loaded sample instead of playing silence.
module i2s_serializer #(
    parameter int SCK_DIV = 4
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        play_in,
    input  logic [47:0] audio_in,
    input  logic        valid_in,
    output logic        req_out,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out
);
    // state | meaning
    // IDLE  | stopped, outputs low, buffer empty
    // WAIT  | first sample requested, loads straight into the shift register
    // RUN   | streaming frames, refill from prefetch buffer at each boundary
    // DRAIN | play dropped, finish current frame then stop
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int DIV_W = $clog2(SCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [5:0]       BIT_LAST = 6'd47;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [47:0]      shift_q, shift_d;
    logic [47:0]      buf_q, buf_d;
    logic             full_q, full_d;
    logic             req_q, req_d;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic             running_d;
`ifdef I2S_HOLD_LAST_EN
    logic [47:0]      last_q, last_d;
`endif

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        buf_d     = buf_q;
        full_d    = full_q;
        req_d     = 1'b0;
`ifdef I2S_HOLD_LAST_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                shift_d   = '0;
                full_d    = 1'b0;
                if (play_in) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!play_in) begin
                    state_d = ST_IDLE;
                end else if (valid_in) begin
                    shift_d   = audio_in;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    req_d     = 1'b1;
                    state_d   = ST_RUN;
`ifdef I2S_HOLD_LAST_EN
                    last_d    = audio_in;
`endif
                end
            end
            default: begin
                state_d = play_in ? ST_RUN : ST_DRAIN;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        // A boundary seen while play is high behaves as RUN even from DRAIN.
                        if (state_q == ST_RUN || play_in) begin
                            req_d = 1'b1;
                            if (full_q) begin
                                shift_d = buf_q;
                                full_d  = 1'b0;
`ifdef I2S_HOLD_LAST_EN
                                last_d  = buf_q;
`endif
                            end else begin
`ifdef I2S_HOLD_LAST_EN
                                shift_d = last_q;
`else
                                shift_d = '0;
`endif
                            end
                        end else begin
                            state_d = ST_IDLE;
                            shift_d = '0;
                            full_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        shift_d   = {shift_q[46:0], 1'b0};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
                // Written after the boundary so a same-cycle strobe refills rather than bypasses.
                if (valid_in && state_d != ST_IDLE) begin
                    buf_d  = audio_in;
                    full_d = 1'b1;
                end
            end
        endcase

        running_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        sck_d     = running_d && (div_cnt_d >= DIV_HALF);
        ws_d      = running_d && (bit_cnt_d >= 6'd23) && (bit_cnt_d <= 6'd46);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            buf_q     <= '0;
            full_q    <= 1'b0;
            req_q     <= 1'b0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
`ifdef I2S_HOLD_LAST_EN
            last_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            buf_q     <= buf_d;
            full_q    <= full_d;
            req_q     <= req_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
`ifdef I2S_HOLD_LAST_EN
            last_q    <= last_d;
`endif
        end
    end

    assign req_out = req_q;
    assign sck_out = sck_q;
    assign ws_out  = ws_q;
    assign sdo_out = shift_q[47];

endmodule

// File: tb/tb_i2s_serializer.sv
// Self-checking bench for i2s_serializer: vector table, cycle-exact single frame, and a
// frame-level reference model for streaming, underrun, collision and stop scenarios.
module tb_i2s_serializer;
    localparam int DIV = 4;
    localparam int FRAME = 48 * DIV;
`ifdef I2S_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        mclk;
    logic        rst;
    logic        play_in;
    logic [47:0] audio_in;
    logic        valid_in;
    logic        req_out;
    logic        sck_out;
    logic        ws_out;
    logic        sdo_out;

    i2s_serializer #(.SCK_DIV(DIV)) dut (
        .mclk     (mclk),
        .rst      (rst),
        .play_in  (play_in),
        .audio_in (audio_in),
        .valid_in (valid_in),
        .req_out  (req_out),
        .sck_out  (sck_out),
        .ws_out   (ws_out),
        .sdo_out  (sdo_out)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    // Receiver view: {ws, sdo} captured on every rising sck.
    logic [1:0]  bits[$];
    always @(posedge sck_out) bits.push_back({ws_out, sdo_out});

    logic [47:0] exp_q[$];
    logic [47:0] last_exp;
    int          base;

    typedef struct {
        logic        rst;
        logic        play;
        logic        valid;
        logic [47:0] audio;
        logic [3:0]  exp;   // {req, sck, ws, sdo}
    } vec_t;
    vec_t vecs[18];

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    // Word select is high for the right channel, advanced one bit ahead of the data.
    function automatic logic [47:0] ws_pattern();
        logic [47:0] p;
        for (int i = 0; i < 48; i++) p[47-i] = (i >= 23 && i <= 46);
        return p;
    endfunction

    task automatic push_exp(input logic [47:0] w);
        exp_q.push_back(w);
        last_exp = w;
    endtask

    task automatic push_underrun();
        push_exp(HOLD ? last_exp : 48'h0);
    endtask

    task automatic start_play(input logic [47:0] s);
        int n;
        play_in = 1'b1;
        n = 0;
        tick();
        while (!req_out && n < 10) begin
            tick();
            n++;
        end
        chk("start_req", req_out, 1);
        tick();
        tick();
        base = bits.size();
        exp_q.delete();
        push_exp(s);
        valid_in = 1'b1;
        audio_in = s;
        tick();
        valid_in = 1'b0;
        chk("load_req", req_out, 1);
        chk("load_sdo", sdo_out, s[47]);
    endtask

    // One frame from a req pulse to the next; valid strobes at frame offsets d1/d2.
    task automatic run_frame(input int nv, input int d1, input logic [47:0] a1,
                             input int d2, input logic [47:0] a2);
        logic bad;
        bad = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            valid_in = (nv >= 1 && c == d1) || (nv >= 2 && c == d2);
            audio_in = (nv >= 2 && c == d2) ? a2 : a1;
            tick();
            if ((c < FRAME - 1) ? req_out : !req_out) bad = 1'b1;
        end
        valid_in = 1'b0;
        chk("req_period", bad, 0);
    endtask

    task automatic stop_and_verify();
        int n_req;
        int nf;
        logic [47:0] w;
        logic [47:0] wsw;
        logic [1:0]  b;
        repeat (5 * DIV) tick();
        play_in = 1'b0;
        n_req = 0;
        repeat (FRAME + 60) begin
            tick();
            if (req_out) n_req++;
        end
        chk("drain_no_req", n_req, 0);
        chk("drain_idle_outputs", {req_out, sck_out, ws_out, sdo_out}, 0);
        chk("frame_bit_count", bits.size() - base, 48 * exp_q.size());
        nf = (bits.size() - base) / 48;
        for (int k = 0; k < exp_q.size() && k < nf; k++) begin
            w = '0;
            wsw = '0;
            for (int i = 0; i < 48; i++) begin
                b = bits[base + 48 * k + i];
                w = {w[46:0], b[0]};
                wsw = {wsw[46:0], b[1]};
            end
            chk($sformatf("frame%0d_data", k), w, exp_q[k]);
            chk($sformatf("frame%0d_ws", k), wsw, ws_pattern());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] s_ref;
        logic [47:0] sa;
        logic [47:0] sb;
        int mode;
        int d1;
        int d2;
        int bitn;

        rst = 1'b1;
        play_in = 1'b0;
        valid_in = 1'b0;
        audio_in = '0;
        last_exp = '0;
        base = 0;
        s_ref = 48'hA5A5A5_5A5A5A;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 48'h0,  4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b1000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, s_ref,  4'b1001};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0001};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0101};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0101};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0100};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0100};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b0001};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 48'h0,  4'b0000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, s_ref,  4'b0000};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b1000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 48'h0,  4'b0000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 48'h0,  4'b1000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 48'h0,  4'b0000};

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            play_in = vecs[i].play;
            valid_in = vecs[i].valid;
            audio_in = vecs[i].audio;
            tick();
            chk($sformatf("vec%0d", i), {req_out, sck_out, ws_out, sdo_out}, vecs[i].exp);
        end
        rst = 1'b0;
        valid_in = 1'b0;
        play_in = 1'b0;
        tick();

        // Reset at bit 10 of a running frame.
        start_play(48'h123456_789ABC);
        repeat (10 * DIV) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_outputs", {req_out, sck_out, ws_out, sdo_out}, 0);
        rst = 1'b0;
        tick();
        chk("rst_mid_req", req_out, 1);
        play_in = 1'b0;
        tick();
        tick();

        // Cycle-exact single frame.
        start_play(s_ref);
        for (int j = 0; j < FRAME; j++) begin
            bitn = j / DIV;
            chk("single_sdo", sdo_out, s_ref[47 - bitn]);
            chk("single_sck", sck_out, (j % DIV) >= DIV / 2);
            chk("single_ws", ws_out, (bitn >= 23 && bitn <= 46));
            tick();
        end
        chk("single_next_req", req_out, 1);
        play_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Streaming with the reference model.
        start_play(rnd48());
        for (int k = 0; k < 4; k++) begin
            sa = rnd48();
            run_frame(1, 20, sa, 0, 48'h0);
            push_exp(sa);
        end
        for (int k = 0; k < 6; k++) begin
            mode = $urandom_range(0, 2);
            d1 = $urandom_range(0, 150);
            d2 = $urandom_range(d1 + 1, FRAME - 3);
            sa = rnd48();
            sb = rnd48();
            if (mode == 0) begin
                run_frame(1, d1, sa, 0, 48'h0);
                push_exp(sa);
            end else if (mode == 1) begin
                run_frame(0, 0, 48'h0, 0, 48'h0);
                push_underrun();
            end else begin
                run_frame(2, d1, sa, d2, sb);
                push_exp(sb);
            end
        end
        // Strobe on the boundary cycle lands one frame later.
        sa = rnd48();
        run_frame(1, FRAME - 1, sa, 0, 48'h0);
        push_underrun();
        run_frame(0, 0, 48'h0, 0, 48'h0);
        push_exp(sa);
        sa = rnd48();
        sb = rnd48();
        run_frame(2, 30, sa, 100, sb);
        push_exp(sb);
        run_frame(0, 0, 48'h0, 0, 48'h0);
        push_underrun();
        stop_and_verify();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
